// File: rtl/ps2_synth_pkg.sv
// Shared scan-code constants, parser state and note lookup for the PS/2 synth key decoder.
package ps2_synth_pkg;

  localparam int unsigned CODE_W    = 8;
  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned VIDX_W    = 3;
  localparam int unsigned OCT_W     = 3;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned NUM_NOTES = 12;

  localparam logic [CODE_W-1:0] SC_BREAK   = 8'hF0;
  localparam logic [CODE_W-1:0] SC_EXT     = 8'hE0;
  localparam logic [CODE_W-1:0] SC_OCT_DN  = 8'h1A;
  localparam logic [CODE_W-1:0] SC_OCT_UP  = 8'h22;
  localparam logic [CODE_W-1:0] SC_SEL_AMP = 8'h16;
  localparam logic [CODE_W-1:0] SC_SEL_ATK = 8'h1E;
  localparam logic [CODE_W-1:0] SC_SEL_DEC = 8'h26;
  localparam logic [CODE_W-1:0] SC_SEL_SUS = 8'h25;
  localparam logic [CODE_W-1:0] SC_SEL_REL = 8'h2E;
  localparam logic [CODE_W-1:0] SC_PAR_DEC = 8'h21;
  localparam logic [CODE_W-1:0] SC_PAR_INC = 8'h2A;

  // Make codes indexed by semitone 0..11
  localparam logic [CODE_W-1:0] NOTE_CODES [NUM_NOTES] = '{
    8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
    8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B
  };

  localparam logic [SEL_W-1:0] SEL_AMP = 3'd0;
  localparam logic [SEL_W-1:0] SEL_ATK = 3'd1;
  localparam logic [SEL_W-1:0] SEL_DEC = 3'd2;
  localparam logic [SEL_W-1:0] SEL_SUS = 3'd3;
  localparam logic [SEL_W-1:0] SEL_REL = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } parser_state_t;

  typedef struct packed {
    logic              hit;
    logic [NOTE_W-1:0] note;
  } note_lu_t;

  function automatic note_lu_t note_lookup(input logic [CODE_W-1:0] code);
    note_lu_t r;
    r = '0;
    for (int i = 0; i < int'(NUM_NOTES); i++) begin
      if (code == NOTE_CODES[i]) begin
        r.hit  = 1'b1;
        r.note = NOTE_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_voice_alloc.sv
// Polyphonic voice table: lowest-free allocation on make, gate release on break.
// Build option PS2_TYPEMATIC_FILTER_EN suppresses note_on for repeated makes of a held note.
module ps2_voice_alloc
  import ps2_synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         make_valid,
  input  logic                         brk_valid,
  input  logic [NOTE_W-1:0]            note,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic                         note_on,
  output logic [VIDX_W-1:0]            note_on_voice,
  output logic                         drop
);

  logic                  match_hit_c;
  logic [NUM_VOICES-1:0] match_vec_c;
  logic                  free_hit_c;
  logic [NUM_VOICES-1:0] free_oh_c;

  // Descending scan so the lowest-index free voice wins
  always_comb begin
    match_hit_c = 1'b0;
    match_vec_c = '0;
    free_hit_c  = 1'b0;
    free_oh_c   = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (voice_gate[i] && (voice_note[NOTE_W*i +: NOTE_W] == note)) begin
        match_hit_c    = 1'b1;
        match_vec_c[i] = 1'b1;
      end
      if (!voice_gate[i]) begin
        free_hit_c   = 1'b1;
        free_oh_c    = '0;
        free_oh_c[i] = 1'b1;
      end
    end
  end

`ifndef PS2_TYPEMATIC_FILTER_EN
  logic [VIDX_W-1:0] match_idx_c;

  always_comb begin
    match_idx_c = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (match_vec_c[i]) match_idx_c = VIDX_W'(i);
    end
  end
`endif

  logic [VIDX_W-1:0] free_idx_c;

  always_comb begin
    free_idx_c = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (free_oh_c[i]) free_idx_c = VIDX_W'(i);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      voice_note    <= '0;
      voice_gate    <= '0;
      note_on       <= 1'b0;
      note_on_voice <= '0;
      drop          <= 1'b0;
    end else begin
      note_on <= 1'b0;
      drop    <= 1'b0;
      if (make_valid) begin
        if (match_hit_c) begin
`ifndef PS2_TYPEMATIC_FILTER_EN
          note_on       <= 1'b1;
          note_on_voice <= match_idx_c;
`endif
        end else if (free_hit_c) begin
          for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (free_oh_c[i]) begin
              voice_note[NOTE_W*i +: NOTE_W] <= note;
              voice_gate[i]                  <= 1'b1;
            end
          end
          note_on       <= 1'b1;
          note_on_voice <= free_idx_c;
        end else begin
          drop <= 1'b1;
        end
      end else if (brk_valid) begin
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
          if (match_vec_c[i]) voice_gate[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code parser driving a synth voice allocator, octave and parameter controls.
// Build option PS2_TYPEMATIC_FILTER_EN (see ps2_voice_alloc) filters repeated note makes.
module ps2_key_decoder
  import ps2_synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned OCT_DEFAULT = 4
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [CODE_W-1:0]            rx_data,
  input  logic                         rx_valid,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic                         note_on,
  output logic [VIDX_W-1:0]            note_on_voice,
  output logic                         drop,
  output logic [OCT_W-1:0]             octave,
  output logic [SEL_W-1:0]             param_sel,
  output logic                         param_inc,
  output logic                         param_dec
);

  parser_state_t state_q, state_d;
  note_lu_t      lu_c;
  logic          make_c;
  logic          brk_c;
  logic          make_note_c;
  logic          brk_note_c;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Prefix bytes steer the parser; every other byte lands back in IDLE
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_BREAK)    state_d = ST_BRK;
          else if (rx_data == SC_EXT) state_d = ST_EXT;
          else                        state_d = ST_IDLE;
        end
        ST_EXT:  state_d = (rx_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Extended-prefix sequences decode to neither make nor break
  always_comb begin
    lu_c        = note_lookup(rx_data);
    make_c      = rx_valid && (state_q == ST_IDLE) &&
                  (rx_data != SC_BREAK) && (rx_data != SC_EXT);
    brk_c       = rx_valid && (state_q == ST_BRK);
    make_note_c = make_c && lu_c.hit;
    brk_note_c  = brk_c && lu_c.hit;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      octave    <= OCT_W'(OCT_DEFAULT);
      param_sel <= SEL_AMP;
      param_inc <= 1'b0;
      param_dec <= 1'b0;
    end else begin
      param_inc <= make_c && (rx_data == SC_PAR_INC);
      param_dec <= make_c && (rx_data == SC_PAR_DEC);
      if (make_c) begin
        case (rx_data)
          SC_OCT_DN:  if (octave != '0)       octave <= octave - OCT_W'(1);
          SC_OCT_UP:  if (octave != 3'd7)     octave <= octave + OCT_W'(1);
          SC_SEL_AMP: param_sel <= SEL_AMP;
          SC_SEL_ATK: param_sel <= SEL_ATK;
          SC_SEL_DEC: param_sel <= SEL_DEC;
          SC_SEL_SUS: param_sel <= SEL_SUS;
          SC_SEL_REL: param_sel <= SEL_REL;
          default: ;
        endcase
      end
    end
  end

  ps2_voice_alloc #(
    .NUM_VOICES (NUM_VOICES)
  ) u_voice_alloc (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .make_valid    (make_note_c),
    .brk_valid     (brk_note_c),
    .note          (lu_c.note),
    .voice_note    (voice_note),
    .voice_gate    (voice_gate),
    .note_on       (note_on),
    .note_on_voice (note_on_voice),
    .drop          (drop)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: behavioural key/voice model plus directed scenarios.
module tb_ps2_key_decoder;

  localparam int NV = 4;
  localparam int OD = 4;

  logic           CLOCK_50 = 1'b0;
  logic           reset    = 1'b0;
  logic [7:0]     rx_data  = 8'h00;
  logic           rx_valid = 1'b0;
  logic [4*NV-1:0] voice_note;
  logic [NV-1:0]  voice_gate;
  logic           note_on;
  logic [2:0]     note_on_voice;
  logic           drop;
  logic [2:0]     octave;
  logic [2:0]     param_sel;
  logic           param_inc;
  logic           param_dec;

  ps2_key_decoder #(.NUM_VOICES(NV), .OCT_DEFAULT(OD)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .voice_note    (voice_note),
    .voice_gate    (voice_gate),
    .note_on       (note_on),
    .note_on_voice (note_on_voice),
    .drop          (drop),
    .octave        (octave),
    .param_sel     (param_sel),
    .param_inc     (param_inc),
    .param_dec     (param_dec)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Model state: what a listener of the key stream must observe
  int m_note [NV];
  bit m_gate [NV];
  int m_oct, m_sel, e_nov;
  bit e_on, e_drop, e_inc, e_dec, nov_known;
  bit saw_brk, saw_ext;
  bit check_en = 1'b0;
  int cnt_on, cnt_inc;

  function automatic int note_of(input logic [7:0] b);
    case (b)
      8'h1C: return 0;  8'h1D: return 1;  8'h1B: return 2;  8'h24: return 3;
      8'h23: return 4;  8'h2B: return 5;  8'h2C: return 6;  8'h34: return 7;
      8'h35: return 8;  8'h33: return 9;  8'h3C: return 10; 8'h3B: return 11;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic key_make(input logic [7:0] b);
    int n, held, free;
    n = note_of(b);
    if (n >= 0) begin
      held = -1;
      free = -1;
      for (int i = NV - 1; i >= 0; i--) begin
        if (m_gate[i] && m_note[i] == n) held = i;
        if (!m_gate[i]) free = i;
      end
      if (held >= 0) begin
`ifndef PS2_TYPEMATIC_FILTER_EN
        e_on = 1; e_nov = held; nov_known = 1;
`endif
      end else if (free >= 0) begin
        m_note[free] = n; m_gate[free] = 1;
        e_on = 1; e_nov = free; nov_known = 1;
      end else begin
        e_drop = 1;
      end
    end
    case (b)
      8'h1A: if (m_oct > 0) m_oct--;
      8'h22: if (m_oct < 7) m_oct++;
      8'h16: m_sel = 0;
      8'h1E: m_sel = 1;
      8'h26: m_sel = 2;
      8'h25: m_sel = 3;
      8'h2E: m_sel = 4;
      8'h2A: e_inc = 1;
      8'h21: e_dec = 1;
      default: ;
    endcase
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit r);
    int n;
    e_on = 0; e_drop = 0; e_inc = 0; e_dec = 0; nov_known = 0;
    if (r) begin
      for (int i = 0; i < NV; i++) begin m_note[i] = 0; m_gate[i] = 0; end
      m_oct = OD; m_sel = 0; e_nov = 0; nov_known = 1;
      saw_brk = 0; saw_ext = 0;
    end else if (v) begin
      if (!saw_brk && b == 8'hF0) saw_brk = 1;
      else if (!saw_brk && !saw_ext && b == 8'hE0) saw_ext = 1;
      else begin
        if (!saw_ext) begin
          if (saw_brk) begin
            n = note_of(b);
            for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == n) m_gate[i] = 0;
          end else begin
            key_make(b);
          end
        end
        saw_brk = 0; saw_ext = 0;
      end
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] b, input bit r);
    @(negedge CLOCK_50);
    rx_valid = v; rx_data = b; reset = r;
    @(posedge CLOCK_50);
    #1;
    model_step(v, b, r);
    rx_valid = 1'b0; reset = 1'b0;
    cnt_on  += int'(note_on);
    cnt_inc += int'(param_inc);
  endtask

  task automatic key(input logic [7:0] b);
    tick(1'b1, b, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 8'h00, 1'b1);
    cnt_on = 0; cnt_inc = 0;
  endtask

  // Per-cycle comparison against the model, sampled mid-period
  always @(negedge CLOCK_50) begin
    if (check_en) begin
      for (int i = 0; i < NV; i++) begin
        chk($sformatf("gate%0d", i), int'(voice_gate[i]), int'(m_gate[i]));
        chk($sformatf("note%0d", i), int'(voice_note[4*i +: 4]), m_note[i]);
      end
      chk("note_on", int'(note_on), int'(e_on));
      chk("drop", int'(drop), int'(e_drop));
      chk("param_inc", int'(param_inc), int'(e_inc));
      chk("param_dec", int'(param_dec), int'(e_dec));
      chk("octave", int'(octave), m_oct);
      chk("param_sel", int'(param_sel), m_sel);
      if (nov_known) chk("note_on_voice", int'(note_on_voice), e_nov);
    end
  end

  logic [7:0] note_codes [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                  8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
  logic [7:0] ctrl_codes [9]  = '{8'h1A, 8'h22, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h21, 8'h2A};
  int exp_oct [4] = '{5, 6, 7, 7};

  initial begin
    int r;
    logic [7:0] b;

    do_reset();
    check_en = 1'b1;
    chk("rst_gate", int'(voice_gate), 0);
    chk("rst_octave", int'(octave), 4);
    chk("rst_sel", int'(param_sel), 0);

    // Single note make then break
    key(8'h1C);
    chk("s1_gate", int'(voice_gate), 1);
    chk("s1_on", int'(note_on), 1);
    chk("s1_voice", int'(note_on_voice), 0);
    chk("s1_note", int'(voice_note[3:0]), 0);
    key(8'hF0); key(8'h1C);
    chk("s1_release", int'(voice_gate), 0);

    // Exhaust four voices
    do_reset();
    key(8'h1C); key(8'h1B); key(8'h23); key(8'h2B); key(8'h34);
    chk("s2_drop", int'(drop), 1);
    chk("s2_gate", int'(voice_gate), 15);
    chk("s2_notes", int'(voice_note), 'h5420);

    // Octave saturation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      key(8'h22);
      chk("s3_oct_up", int'(octave), exp_oct[i]);
    end
    for (int i = 0; i < 8; i++) key(8'h1A);
    chk("s3_oct_floor", int'(octave), 0);

    // Parameter select and increment, break ignored
    do_reset();
    key(8'h26); key(8'h2A); key(8'hF0); key(8'h2A);
    tick(1'b0, 8'h00, 1'b0);
    chk("s4_sel", int'(param_sel), 2);
    chk("s4_inc_count", cnt_inc, 1);

    // Extended codes ignored; repeated make
    do_reset();
    key(8'hE0); key(8'h1C); key(8'hE0); key(8'hF0); key(8'h1C);
    chk("s5_ext_gate", int'(voice_gate), 0);
    chk("s5_ext_on", cnt_on, 0);
    key(8'h1C); key(8'h1C);
    tick(1'b0, 8'h00, 1'b0);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("s5_repeat_on", cnt_on, 1);
`else
    chk("s5_repeat_on", cnt_on, 2);
`endif
    chk("s5_repeat_gate", int'(voice_gate), 1);

    // Reset between F0 and the next byte
    do_reset();
    key(8'hF0);
    do_reset();
    key(8'h1B);
    chk("s6_gate", int'(voice_gate), 1);
    chk("s6_note", int'(voice_note[3:0]), 2);

    // Reset coincident with a byte discards it
    tick(1'b1, 8'h1D, 1'b1);
    chk("s7_rst_prio", int'(voice_gate), 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        tick(1'b0, 8'h00, 1'b1);
      end else if (r < 20) begin
        tick(1'b0, 8'($urandom), 1'b0);
      end else begin
        r = $urandom_range(0, 99);
        if (r < 50)      b = note_codes[$urandom_range(0, 11)];
        else if (r < 72) b = 8'hF0;
        else if (r < 80) b = 8'hE0;
        else if (r < 93) b = ctrl_codes[$urandom_range(0, 8)];
        else if (r < 96) b = 8'($urandom);
        else             b = (r[0]) ? 8'h1C : 8'h1B;
        if (r >= 2 && ($urandom_range(0, 9) == 0)) tick(1'b1, b, 1'b1);
        else                                       key(b);
      end
    end
    tick(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
